// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, reads the program ROM a byte per cycle and
// assembles 1-3 byte instructions for the decoder over valid/ready.
module instr_fetch #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        jump_valid,
   input  logic [15:0] jump_addr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  instr_opcode,
   output logic [15:0] instr_operand,
   output logic [1:0]  instr_len,
   output logic [15:0] instr_pc
);

   typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, HOLD} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [15:0] operand_q, operand_d;
   logic [1:0]  len_q, len_d;
   logic [15:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic [1:0]  op_len;
   logic        take_op, take_lo, take_hi;

   assign op_len = rom_data[7:6] == 2'b00 ? 2'd1 : rom_data[7:6] == 2'b01 ? 2'd2 : 2'd3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH_OP;
      else        state_q <= state_d;
   end

   // A redirect overrides every transition and discards partial work.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_OP: state_d = op_len == 2'd1 ? HOLD : FETCH_LO;
         FETCH_LO: state_d = len_q == 2'd2 ? HOLD : FETCH_HI;
         FETCH_HI: state_d = HOLD;
         HOLD:     state_d = instr_ready ? FETCH_OP : HOLD;
      endcase
      if (jump_valid) state_d = FETCH_OP;
   end

   always_comb begin
      take_op   = state_q == FETCH_OP && !jump_valid;
      take_lo   = state_q == FETCH_LO && !jump_valid;
      take_hi   = state_q == FETCH_HI && !jump_valid;
      pc_d      = jump_valid ? jump_addr : state_q == HOLD ? pc_q : pc_q + 16'd1;
      opcode_d  = take_op ? rom_data : opcode_q;
      len_d     = take_op ? op_len : len_q;
      ipc_d     = take_op ? pc_q : ipc_q;
      operand_d = take_lo ? {(len_q == 2'd2 ? 8'h00 : operand_q[15:8]), rom_data} :
                  take_hi ? {rom_data, operand_q[7:0]} : operand_q;
      valid_d   = state_d == HOLD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_VECTOR;
         opcode_q  <= 8'h00;
         operand_q <= 16'h0000;
         len_q     <= 2'd0;
         ipc_q     <= 16'h0000;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         len_q     <= len_d;
         ipc_q     <= ipc_d;
         valid_q   <= valid_d;
      end
   end

   assign rom_addr      = pc_q;
   assign instr_valid   = valid_q;
   assign instr_opcode  = opcode_q;
   assign instr_operand = operand_q;
   assign instr_len     = len_q;
   assign instr_pc      = ipc_q;

endmodule
